// File: rtl/boxcar_pkg.sv
// Purpose: shared types, widths and width-derivation helpers for the boxcar decimator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: ACC_W default, log/count/accumulator width functions, out_state_e, result_t.
package boxcar_pkg;

  localparam int DEF_IN_WIDTH  = 16;
  localparam int DEF_OUT_WIDTH = 32;
  localparam int DEF_MAX_LOG   = 10;

  // Accumulator width for the default configuration: 2^MAX_LOG samples of
  // IN_WIDTH bits need MAX_LOG extra headroom bits.
  localparam int ACC_W = DEF_IN_WIDTH + DEF_MAX_LOG;

  typedef enum logic {OUT_EMPTY, OUT_FULL} out_state_e;

  typedef logic signed [DEF_OUT_WIDTH-1:0] result_t;

  function automatic int acc_width(input int in_w, input int max_log);
    return in_w + max_log;
  endfunction

  // Width of the log_count port: must hold 0..max_log.
  function automatic int log_width(input int max_log);
    return (max_log < 1) ? 1 : $clog2(max_log + 1);
  endfunction

  // Sample counter runs 0..2^max_log-1.
  function automatic int cnt_width(input int max_log);
    return (max_log < 1) ? 1 : max_log;
  endfunction

endpackage

// File: rtl/boxcar_out_reg.sv
// Purpose: single-entry AXI-Stream output register with drop/overflow tracking.
// Latency: 1 cycle from load_vld to m_tvalid.
// Backpressure: holds m_tdata while m_tvalid & !m_tready; a load arriving then is dropped and sets overflow.
// Ports: clk/rst (sync, active-high), enable (low clears overflow), load_vld/load_dat (completed
//        result), m_tvalid/m_tready/m_tdata (AXI-Stream master), overflow (sticky drop flag).
module boxcar_out_reg
  import boxcar_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             load_vld,
  input  logic [WIDTH-1:0] load_dat,
  output logic             m_tvalid,
  input  logic             m_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             overflow
);

  out_state_e state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= OUT_EMPTY;
      m_tdata  <= '0;
      overflow <= 1'b0;
    end else begin
      // load_vld can only occur while enable is high, so clear and set never collide.
      if (!enable) overflow <= 1'b0;
      case (state_q)
        OUT_EMPTY: begin
          if (load_vld) begin
            state_q <= OUT_FULL;
            m_tdata <= load_dat;
          end
        end
        OUT_FULL: begin
          if (m_tready) begin
            // Slot drains this cycle, so a simultaneous completion refills it.
            if (load_vld) m_tdata <= load_dat;
            else          state_q <= OUT_EMPTY;
          end else if (load_vld) begin
            overflow <= 1'b1;
          end
        end
        default: state_q <= OUT_EMPTY;
      endcase
    end
  end

  assign m_tvalid = (state_q == OUT_FULL);

endmodule

// File: rtl/boxcar_decimator.sv
// Purpose: averages blocks of 2^log_count signed samples and emits one result per block.
// Latency: result valid 1 cycle after the last sample of a block is accepted.
// Backpressure: input never stalls; output honours M_AXIS_tready, dropped results set overflow.
// Ports: aclk/areset (sync, active-high), enable, log_count, S_AXIS_tvalid/tdata (input stream),
//        M_AXIS_tvalid/tready/tdata (averaged output), overflow.
// Option: define BOXCAR_ROUND_EN for round-half-up instead of truncation toward -inf.
module boxcar_decimator
  import boxcar_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 32,
  parameter int MAX_LOG   = 10
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic                          enable,
  input  logic [log_width(MAX_LOG)-1:0] log_count,
  input  logic                          S_AXIS_tvalid,
  input  logic [IN_WIDTH-1:0]           S_AXIS_tdata,
  output logic                          M_AXIS_tvalid,
  input  logic                          M_AXIS_tready,
  output logic [OUT_WIDTH-1:0]          M_AXIS_tdata,
  output logic                          overflow
);

  localparam int LW = log_width(MAX_LOG);
  localparam int CW = cnt_width(MAX_LOG);
  localparam int AW = acc_width(IN_WIDTH, MAX_LOG);
`ifdef BOXCAR_ROUND_EN
  // One extra bit so adding the rounding constant cannot wrap.
  localparam int SUM_W = AW + 1;
`else
  localparam int SUM_W = AW;
`endif
  localparam logic [LW-1:0] MAX_K = LW'(MAX_LOG);

  logic [LW-1:0]          k_q;
  logic [LW-1:0]          k_cur;
  logic [LW-1:0]          log_clamped;
  logic [CW-1:0]          cnt_q;
  logic [CW-1:0]          last_cnt;
  logic signed [AW-1:0]   acc_q;
  logic signed [AW-1:0]   acc_next;
  logic signed [AW-1:0]   sample_ext;
  logic signed [SUM_W-1:0] sum;
  logic signed [SUM_W-1:0] shifted;
  logic signed [OUT_WIDTH-1:0] result;
  logic                   accept;
  logic                   first;
  logic                   last;
  logic                   done;

  assign accept      = enable & S_AXIS_tvalid;
  assign first       = (cnt_q == '0);
  assign log_clamped = (log_count > MAX_K) ? MAX_K : log_count;
  // The first sample of a block uses the live (clamped) log_count; later ones the latched k.
  assign k_cur       = first ? log_clamped : k_q;

  assign sample_ext  = AW'($signed(S_AXIS_tdata));
  assign acc_next    = first ? sample_ext : acc_q + sample_ext;

  // 2^k - 1 as a mask; shifting all-ones by CW yields 0, so k == CW gives all ones.
  assign last_cnt    = ~({CW{1'b1}} << k_cur);
  assign last        = (cnt_q == last_cnt);
  assign done        = accept & last;

`ifdef BOXCAR_ROUND_EN
  logic signed [SUM_W-1:0] round_add;
  assign round_add = (k_cur == '0) ? '0 : (SUM_W'(1) << (k_cur - 1'b1));
  assign sum       = SUM_W'(acc_next) + round_add;
`else
  assign sum       = acc_next;
`endif

  assign shifted = sum >>> k_cur;
  assign result  = OUT_WIDTH'(shifted);

  always_ff @(posedge aclk) begin
    if (areset) begin
      acc_q <= '0;
      cnt_q <= '0;
      k_q   <= '0;
    end else if (!enable) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (accept) begin
      if (first) k_q <= log_clamped;
      acc_q <= acc_next;
      cnt_q <= last ? '0 : cnt_q + 1'b1;
    end
  end

  boxcar_out_reg #(
    .WIDTH(OUT_WIDTH)
  ) u_out_reg (
    .clk      (aclk),
    .rst      (areset),
    .enable   (enable),
    .load_vld (done),
    .load_dat (result),
    .m_tvalid (M_AXIS_tvalid),
    .m_tready (M_AXIS_tready),
    .m_tdata  (M_AXIS_tdata),
    .overflow (overflow)
  );

endmodule

// File: tb/tb_boxcar_decimator.sv
// Purpose: directed self-checking bench for boxcar_decimator (default and BOXCAR_ROUND_EN builds).
// Latency: n/a.
// Backpressure: n/a.
module tb_boxcar_decimator;
  import boxcar_pkg::*;

  logic        aclk = 1'b0;
  logic        areset;
  logic        enable;
  logic [3:0]  log_count;
  logic        S_AXIS_tvalid;
  logic [15:0] S_AXIS_tdata;
  logic        M_AXIS_tvalid;
  logic        M_AXIS_tready;
  logic [31:0] M_AXIS_tdata;
  logic        overflow;

  int checks = 0;
  int errors = 0;

`ifdef BOXCAR_ROUND_EN
  localparam result_t EXP_POS = 3;   // (10+2)>>2
  localparam result_t EXP_NEG = -2;  // (-10+2)>>>2
`else
  localparam result_t EXP_POS = 2;   // 10>>>2
  localparam result_t EXP_NEG = -3;  // floor(-2.5)
`endif

  always #5 aclk = ~aclk;

  boxcar_decimator dut (
    .aclk          (aclk),
    .areset        (areset),
    .enable        (enable),
    .log_count     (log_count),
    .S_AXIS_tvalid (S_AXIS_tvalid),
    .S_AXIS_tdata  (S_AXIS_tdata),
    .M_AXIS_tvalid (M_AXIS_tvalid),
    .M_AXIS_tready (M_AXIS_tready),
    .M_AXIS_tdata  (M_AXIS_tdata),
    .overflow      (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one input cycle; returns at the following falling edge so outputs are settled.
  task automatic cyc(input logic v, input int d);
    S_AXIS_tvalid = v;
    S_AXIS_tdata  = 16'(d);
    @(negedge aclk);
  endtask

  initial begin
    areset        = 1'b1;
    enable        = 1'b0;
    log_count     = 4'd0;
    S_AXIS_tvalid = 1'b0;
    S_AXIS_tdata  = '0;
    M_AXIS_tready = 1'b0;
    @(negedge aclk);
    areset = 1'b0;
    enable = 1'b1;
    check("rst_tvalid", 32'(M_AXIS_tvalid), 32'd0);
    check("rst_tdata", M_AXIS_tdata, 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);

    // Positive block of 4.
    log_count = 4'd2;
    M_AXIS_tready = 1'b1;
    cyc(1'b1, 1); cyc(1'b1, 2); cyc(1'b1, 3);
    check("pos_early_tvalid", 32'(M_AXIS_tvalid), 32'd0);
    cyc(1'b1, 4);
    check("pos_tvalid", 32'(M_AXIS_tvalid), 32'd1);
    check("pos_tdata", M_AXIS_tdata, 32'(EXP_POS));
    cyc(1'b0, 0);
    check("pos_tvalid_drop", 32'(M_AXIS_tvalid), 32'd0);

    // Negative block of 4.
    cyc(1'b1, -1); cyc(1'b1, -2); cyc(1'b1, -3); cyc(1'b1, -4);
    check("neg_tvalid", 32'(M_AXIS_tvalid), 32'd1);
    check("neg_tdata", M_AXIS_tdata, 32'(EXP_NEG));
    cyc(1'b0, 0);

    // Pass-through with k=0.
    log_count = 4'd0;
    for (int i = 0; i < 10; i++) begin
      cyc(1'b1, i);
      check("ramp_tvalid", 32'(M_AXIS_tvalid), 32'd1);
      check("ramp_tdata", M_AXIS_tdata, 32'(i));
    end
    cyc(1'b0, 0);
    check("ramp_end_tvalid", 32'(M_AXIS_tvalid), 32'd0);

    // Backpressure: second block is dropped.
    log_count = 4'd1;
    M_AXIS_tready = 1'b0;
    cyc(1'b1, 10); cyc(1'b1, 10);
    check("bp1_tvalid", 32'(M_AXIS_tvalid), 32'd1);
    check("bp1_tdata", M_AXIS_tdata, 32'd10);
    check("bp1_ovf", 32'(overflow), 32'd0);
    cyc(1'b1, 20); cyc(1'b1, 20);
    check("bp2_tdata_held", M_AXIS_tdata, 32'd10);
    check("bp2_ovf", 32'(overflow), 32'd1);
    M_AXIS_tready = 1'b1;
    cyc(1'b0, 0);
    check("bp_drain_tvalid", 32'(M_AXIS_tvalid), 32'd0);
    check("bp_drain_ovf", 32'(overflow), 32'd1);
    enable = 1'b0;
    cyc(1'b0, 0);
    check("en_low_ovf", 32'(overflow), 32'd0);

    // enable low discards a partial block and ignores samples.
    enable = 1'b1;
    cyc(1'b1, 100);
    enable = 1'b0;
    cyc(1'b1, 50);
    enable = 1'b1;
    cyc(1'b1, 2);
    check("en_partial_tvalid", 32'(M_AXIS_tvalid), 32'd0);
    cyc(1'b1, 4);
    check("en_new_tvalid", 32'(M_AXIS_tvalid), 32'd1);
    check("en_new_tdata", M_AXIS_tdata, 32'd3);
    cyc(1'b0, 0);

    // tready coincident with completion: replace, no overflow.
    M_AXIS_tready = 1'b0;
    cyc(1'b1, 1); cyc(1'b1, 3);
    check("co1_tdata", M_AXIS_tdata, 32'd2);
    cyc(1'b1, 5);
    check("co_hold_tdata", M_AXIS_tdata, 32'd2);
    M_AXIS_tready = 1'b1;
    cyc(1'b1, 7);
    check("co2_tvalid", 32'(M_AXIS_tvalid), 32'd1);
    check("co2_tdata", M_AXIS_tdata, 32'd6);
    check("co2_ovf", 32'(overflow), 32'd0);
    cyc(1'b0, 0);
    check("co_drain_tvalid", 32'(M_AXIS_tvalid), 32'd0);

    // log_count above MAX_LOG clamps to 1024 samples.
    log_count = 4'd15;
    for (int i = 0; i < 1023; i++) cyc(1'b1, 1);
    check("clamp_early_tvalid", 32'(M_AXIS_tvalid), 32'd0);
    cyc(1'b1, 1);
    check("clamp_tvalid", 32'(M_AXIS_tvalid), 32'd1);
    check("clamp_tdata", M_AXIS_tdata, 32'd1);
    cyc(1'b0, 0);

    // Reset mid-block with a pending output and overflow set.
    M_AXIS_tready = 1'b0;
    log_count = 4'd0;
    cyc(1'b1, 9);
    check("pre_rst_tdata", M_AXIS_tdata, 32'd9);
    cyc(1'b1, 9);
    check("pre_rst_ovf", 32'(overflow), 32'd1);
    log_count = 4'd3;
    cyc(1'b1, 7); cyc(1'b1, 7); cyc(1'b1, 7);
    areset = 1'b1;
    cyc(1'b0, 0);
    areset = 1'b0;
    check("mid_rst_tvalid", 32'(M_AXIS_tvalid), 32'd0);
    check("mid_rst_tdata", M_AXIS_tdata, 32'd0);
    check("mid_rst_ovf", 32'(overflow), 32'd0);

    // Fresh block of 8; log_count change mid-block must not shorten it.
    M_AXIS_tready = 1'b1;
    cyc(1'b1, 5);
    log_count = 4'd1;
    cyc(1'b1, 5);
    check("k_latch_early_tvalid", 32'(M_AXIS_tvalid), 32'd0);
    for (int i = 0; i < 5; i++) cyc(1'b1, 5);
    check("k_latch_7_tvalid", 32'(M_AXIS_tvalid), 32'd0);
    cyc(1'b1, 5);
    check("k_latch_tvalid", 32'(M_AXIS_tvalid), 32'd1);
    check("k_latch_tdata", M_AXIS_tdata, 32'd5);
    cyc(1'b1, 4);
    check("k_new_early_tvalid", 32'(M_AXIS_tvalid), 32'd0);
    cyc(1'b1, 8);
    check("k_new_tvalid", 32'(M_AXIS_tvalid), 32'd1);
    check("k_new_tdata", M_AXIS_tdata, 32'd6);
    cyc(1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/boxcar_decimator.md
Name: boxcar_decimator

Overview:
- Upstream stage of the RAM writer. Accumulates 2^log_count consecutive signed samples from the acquisition stream.
- Emits one averaged sample per block on an AXI-Stream master. The RAM writer consumes this stream.
- Reduces sample rate and noise before storage. The input stream has no backpressure; the output stream honours tready.

Parameters:
- IN_WIDTH, 16, signed input sample width.
- OUT_WIDTH, 32, output tdata width. The averaged value is sign-extended into it.
- MAX_LOG, 10, largest legal log_count. Sets accumulator width ACC_W = IN_WIDTH + MAX_LOG.

Ports:
- aclk  in  1  clock.
- areset  in  1  synchronous, active-high reset.
- enable  in  1  run control. Low clears the block in progress.
- log_count  in  $clog2(MAX_LOG+1)  block length is 2^log_count samples.
- S_AXIS_tvalid  in  1  input sample valid. No tready; the input is always accepted.
- S_AXIS_tdata  in  IN_WIDTH  signed input sample.
- M_AXIS_tvalid  out  1  averaged result valid.
- M_AXIS_tready  in  1  downstream accept.
- M_AXIS_tdata  out  OUT_WIDTH  averaged result, sign-extended.
- overflow  out  1  sticky flag: a completed result was dropped.

Behaviour:
- Reset: one clock, synchronous and active-high. Name aclk/areset.
  - Clears acc, cnt, the latched k, overflow, M_AXIS_tvalid and M_AXIS_tdata.
  - Reset mid-block discards all partial state.
- Latching k:
  - k is latched from log_count when the first sample of a block is accepted.
  - Changes to log_count mid-block take effect at the next block.
  - log_count > MAX_LOG is clamped to MAX_LOG.
- Per accepted sample (enable & S_AXIS_tvalid):
  - acc <= (cnt==0 ? sample : acc + sample), with ACC_W-bit signed arithmetic. Overflow of acc is impossible by construction.
  - cnt increments. When cnt reaches 2^k - 1 on the current sample, the block completes this cycle and cnt returns to 0.
- Result value:
  - result = (acc_final) >>> k, arithmetic shift.
  - Truncates toward negative infinity.
  - Low OUT_WIDTH bits of the sign-extended value go to tdata.
- Latency: M_AXIS_tvalid asserts on the clock edge after the last sample of a block is accepted (1 cycle).
- With k=0, every sample passes through with 1-cycle latency.
- Output register, single entry. It acts as a state machine over M_AXIS_tvalid (EMPTY/FULL):
  - EMPTY + completion -> FULL, load result.
  - FULL + tready, no completion -> EMPTY.
  - FULL + tready + completion in the same cycle -> stays FULL, loads the new result, no overflow.
  - FULL + no tready + completion -> new result is dropped, old tdata is held, overflow <= 1.
  - tdata is stable while tvalid & !tready (AXI-Stream rule).
- enable low:
  - Clears acc and cnt; samples are ignored.
  - A pending output is kept until accepted.
  - overflow is cleared.
- enable rising: the next accepted sample starts a new block with a fresh k.

Optional Feature:
- Macro: BOXCAR_ROUND_EN.
- Defined: before the shift, add 2^(k-1) when k>0, giving round-half-up. The accumulator carries one extra bit for this, so no wrap occurs. Adds no latency.
- Undefined: plain truncating arithmetic shift as above.

Decomposition:
- Shared package boxcar_pkg holds:
  - ACC_W and the count-width derivation functions.
  - The out_state_e enum {OUT_EMPTY, OUT_FULL}.
  - A result_t typedef of OUT_WIDTH signed.
- One sub-module, boxcar_out_reg: the single-entry AXI-Stream output register, with load/drop/overflow logic.
- The top module holds the accumulator, counter, k latch and rounding.

Test Plan:
1. log_count=2, inputs 1,2,3,4 every cycle, tready=1 -> tdata=2 one cycle after sample 4, tvalid for one cycle. With BOXCAR_ROUND_EN -> 3.
2. log_count=2, inputs -1,-2,-3,-4 -> tdata=32'hFFFFFFFD (-3). With BOXCAR_ROUND_EN -> 32'hFFFFFFFE (-2).
3. log_count=0, stream ramp 0..9 -> output ramp 0..9, each delayed 1 cycle; no gaps with tready=1.
4. log_count=1, inputs 10,10,20,20, tready=0 throughout -> tdata holds 10, overflow=1 after the second block. Then tready=1 -> 10 accepted, tvalid drops. enable low -> overflow=0.
5. log_count=1, tready pulsed high exactly on the completion cycle of the second block -> first result accepted, second loaded, overflow stays 0.
6. Mid-block (after 3 of 8 samples, log_count=3), assert areset for 1 cycle -> all outputs 0. Next 8 samples of value 5 -> tdata=5. Change log_count 3->1 mid-block -> the current block still uses 8 samples.
